lcd_driver: RTL and testbench

- Character-LCD (HD44780-compatible, 8-bit bus) timing controller. It sits between the core's LSU LCD output register and the physical LCD pins.
- Software hands it one command or data byte per handshake. The block generates the bus timing: address setup, enable pulse, hold and execution wait.
- After reset it runs the power-up wait and a fixed initialisation sequence on its own.

---
 rtl/lcd_driver.sv | 150 +++++++++++++++
 tb/tb_lcd_driver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_driver.sv
// HD44780-style 8-bit character LCD bus timing controller.
// Runs the power-up wait and init sequence, then writes one byte per ready/valid handshake.
module lcd_driver #(
    parameter int T_AS        = 3,
    parameter int T_EN        = 25,
    parameter int T_HOLD      = 3,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000,
    parameter int T_PWRUP     = 800000,
    parameter int CNT_W       = 20
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cmd_vld,
    input  logic       i_cmd_rs,
    input  logic [7:0] i_cmd_data,
    output logic       o_cmd_rdy,
    output logic       o_init_done,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    typedef enum logic [2:0] {PWRUP, SETUP, PULSE, HOLD, EXEC, IDLE} state_t;

    localparam logic [CNT_W-1:0] AS_LAST    = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(T_EXEC_LONG - 1);
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(T_PWRUP - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             rs_reg, rs_next;
    logic [7:0]       data_reg, data_next;
    logic [1:0]       init_idx_reg, init_idx_next;
    logic             init_done_reg, init_done_next;
    logic             exec_long;
    logic [CNT_W-1:0] exec_last;

    // 8-bit bus, 2 lines; display on; clear; entry mode increment.
    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Clear display and return home need the long execution wait.
    assign exec_long = !rs_reg && (data_reg == 8'h01 || data_reg == 8'h02 || data_reg == 8'h03);
    assign exec_last = exec_long ? LONG_LAST : EXEC_LAST;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg     <= PWRUP;
            cnt_reg       <= '0;
            rs_reg        <= 1'b0;
            data_reg      <= 8'h00;
            init_idx_reg  <= 2'd0;
            init_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rs_reg        <= rs_next;
            data_reg      <= data_next;
            init_idx_reg  <= init_idx_next;
            init_done_reg <= init_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg + CNT_W'(1);
        rs_next        = rs_reg;
        data_next      = data_reg;
        init_idx_next  = init_idx_reg;
        init_done_next = init_done_reg;
        case (state_reg)
            PWRUP: begin
                if (cnt_reg == PWRUP_LAST) begin
                    state_next    = SETUP;
                    cnt_next      = '0;
                    rs_next       = 1'b0;
                    data_next     = init_byte(2'd0);
                    init_idx_next = 2'd0;
                end
            end
            SETUP: begin
                if (cnt_reg == AS_LAST) begin
                    state_next = PULSE;
                    cnt_next   = '0;
                end
            end
            PULSE: begin
                if (cnt_reg == EN_LAST) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end
            end
            HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next = EXEC;
                    cnt_next   = '0;
                end
            end
            EXEC: begin
                if (cnt_reg == exec_last) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (!init_done_reg) begin
                        if (init_idx_reg == 2'd3) begin
                            init_done_next = 1'b1;
                        end else begin
                            state_next    = SETUP;
                            init_idx_next = init_idx_reg + 2'd1;
                            rs_next       = 1'b0;
                            data_next     = init_byte(init_idx_reg + 2'd1);
                        end
                    end
                end
            end
            IDLE: begin
                cnt_next = '0;
                if (i_cmd_vld) begin
                    state_next = SETUP;
                    rs_next    = i_cmd_rs;
                    data_next  = i_cmd_data;
                end
            end
            default: begin
                state_next = PWRUP;
                cnt_next   = '0;
            end
        endcase
    end

    assign o_cmd_rdy   = (state_reg == IDLE);
    assign o_init_done = init_done_reg;
    assign o_lcd_on    = ~i_reset;
    assign o_lcd_en    = (state_reg == PULSE);
    assign o_lcd_rs    = rs_reg;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_data  = data_reg;

endmodule

// File: tb/tb_lcd_driver.sv
// Directed bench for lcd_driver with shortened timing: init sequence, table of writes,
// held-valid producer and asynchronous reset in the middle of an enable pulse.
module tb_lcd_driver;

    localparam int T_AS = 2, T_EN = 4, T_HOLD = 2, T_EXEC = 10, T_EXEC_LONG = 50, T_PWRUP = 100;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_cmd_vld = 1'b0;
    logic       i_cmd_rs = 1'b0;
    logic [7:0] i_cmd_data = 8'h00;
    logic       o_cmd_rdy, o_init_done, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
    logic [7:0] o_lcd_data;

    int errors = 0;
    int checks = 0;
    int misc_err = 0;

    lcd_driver #(
        .T_AS(T_AS), .T_EN(T_EN), .T_HOLD(T_HOLD), .T_EXEC(T_EXEC),
        .T_EXEC_LONG(T_EXEC_LONG), .T_PWRUP(T_PWRUP), .CNT_W(20)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_cmd_vld(i_cmd_vld), .i_cmd_rs(i_cmd_rs),
        .i_cmd_data(i_cmd_data), .o_cmd_rdy(o_cmd_rdy), .o_init_done(o_init_done),
        .o_lcd_on(o_lcd_on), .o_lcd_en(o_lcd_en), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
        .o_lcd_data(o_lcd_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         busy;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " en"}, int'(o_lcd_en), 0);
        check({tag, " rdy"}, int'(o_cmd_rdy), 0);
        check({tag, " init_done"}, int'(o_init_done), 0);
        check({tag, " lcd_on"}, int'(o_lcd_on), 0);
        check({tag, " rs"}, int'(o_lcd_rs), 0);
        check({tag, " rw"}, int'(o_lcd_rw), 0);
        check({tag, " data"}, int'(o_lcd_data), 0);
    endtask

    // Called at a negedge right after reset release; sample n follows clock edge n.
    task automatic check_init_seq(input bit noise, input string tag);
        int starts[4];
        logic [7:0] exp_bytes[4];
        logic [7:0] cap[4];
        int n_pulse, rdy_at, done_at, en_err, rs_err;
        logic en_prev, en_exp;
        starts[0] = 102; starts[1] = 120; starts[2] = 138; starts[3] = 196;
        exp_bytes[0] = 8'h38; exp_bytes[1] = 8'h0C; exp_bytes[2] = 8'h01; exp_bytes[3] = 8'h06;
        for (int i = 0; i < 4; i++) cap[i] = 8'hxx;
        n_pulse = 0; rdy_at = -1; done_at = -1; en_err = 0; rs_err = 0; en_prev = 1'b0;
        for (int n = 1; n <= 230; n++) begin
            if (noise) begin
                i_cmd_vld  = (n < 205 && n % 5 == 0) ? 1'b1 : 1'b0;
                i_cmd_rs   = 1'b1;
                i_cmd_data = 8'hAA;
            end
            @(negedge i_clk);
            en_exp = 1'b0;
            for (int i = 0; i < 4; i++)
                if (n >= starts[i] && n < starts[i] + T_EN) en_exp = 1'b1;
            if (o_lcd_en !== en_exp) en_err++;
            if (o_lcd_en && !en_prev) begin
                if (n_pulse < 4) cap[n_pulse] = o_lcd_data;
                if (o_lcd_rs) rs_err++;
                n_pulse++;
            end
            if (o_cmd_rdy && rdy_at < 0) rdy_at = n;
            if (o_init_done && done_at < 0) done_at = n;
            if (!o_lcd_on || o_lcd_rw) misc_err++;
            en_prev = o_lcd_en;
        end
        i_cmd_vld = 1'b0;
        check({tag, " pulse count"}, n_pulse, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s init byte %0d", tag, i), int'(cap[i]), int'(exp_bytes[i]));
        check({tag, " en timing errs"}, en_err, 0);
        check({tag, " init rs errs"}, rs_err, 0);
        check({tag, " rdy rise cycle"}, rdy_at, 212);
        check({tag, " init_done rise cycle"}, done_at, 212);
        $display("init %s: pulses=%0d rdy_at=%0d done_at=%0d", tag, n_pulse, rdy_at, done_at);
    endtask

    // Called at a negedge; sample k follows the k-th edge after the accept edge (k=0 is the accept edge).
    task automatic send_measure(input logic rs, input logic [7:0] d, output int wait_cyc,
                                output int busy, output int en_first, output int en_len,
                                output int bus_err);
        wait_cyc = 0;
        while (!o_cmd_rdy && wait_cyc < 1000) begin
            @(negedge i_clk);
            wait_cyc++;
        end
        i_cmd_vld = 1'b1; i_cmd_rs = rs; i_cmd_data = d;
        @(negedge i_clk);
        i_cmd_vld = 1'b0; i_cmd_rs = ~rs; i_cmd_data = ~d;
        busy = -1; en_first = -1; en_len = 0; bus_err = 0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge i_clk);
            if (!o_lcd_on || o_lcd_rw) misc_err++;
            if (o_lcd_rs !== rs || o_lcd_data !== d) bus_err++;
            if (o_cmd_rdy) begin
                busy = k;
                break;
            end
            if (o_lcd_en) begin
                if (en_first < 0) en_first = k;
                en_len++;
            end
        end
    endtask

    initial begin
        int wait_cyc, busy, en_first, en_len, bus_err;
        logic [7:0] prod_bytes[2];
        logic [7:0] cap[2];
        int idx, n_pulse;
        logic pending, en_prev;

        vecs[0] = '{1'b1, 8'h41, 18};
        vecs[1] = '{1'b0, 8'h01, 58};
        vecs[2] = '{1'b1, 8'h01, 18};
        vecs[3] = '{1'b0, 8'h02, 58};
        vecs[4] = '{1'b0, 8'h03, 58};
        vecs[5] = '{1'b0, 8'h04, 18};
        vecs[6] = '{1'b1, 8'h03, 18};

        #2;
        check_all_zero("reset state");
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        check_init_seq(1'b0, "first");

        foreach (vecs[i]) begin
            send_measure(vecs[i].rs, vecs[i].data, wait_cyc, busy, en_first, en_len, bus_err);
            $display("txn %0d rs=%0d data=%02h wait=%0d busy=%0d en_first=%0d en_len=%0d bus_err=%0d",
                     i, vecs[i].rs, vecs[i].data, wait_cyc, busy, en_first, en_len, bus_err);
            check($sformatf("vec%0d idle wait", i), wait_cyc, 0);
            check($sformatf("vec%0d busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d en start", i), en_first, T_AS);
            check($sformatf("vec%0d en len", i), en_len, T_EN);
            check($sformatf("vec%0d bus stable errs", i), bus_err, 0);
        end

        // Producer holds valid and advances only on accept.
        prod_bytes[0] = 8'h30; prod_bytes[1] = 8'h31;
        cap[0] = 8'hxx; cap[1] = 8'hxx;
        idx = 0; n_pulse = 0; pending = 1'b0; en_prev = 1'b0;
        i_cmd_vld = 1'b1; i_cmd_rs = 1'b1; i_cmd_data = prod_bytes[0];
        if (o_cmd_rdy) pending = 1'b1;
        for (int c = 0; c < 120; c++) begin
            @(negedge i_clk);
            if (o_lcd_en && !en_prev) begin
                if (n_pulse < 2) cap[n_pulse] = o_lcd_data;
                n_pulse++;
            end
            en_prev = o_lcd_en;
            if (pending) begin
                pending = 1'b0;
                idx++;
                if (idx >= 2) i_cmd_vld = 1'b0;
                else i_cmd_data = prod_bytes[idx];
            end
            if (i_cmd_vld && o_cmd_rdy) pending = 1'b1;
        end
        i_cmd_vld = 1'b0;
        $display("held-valid: accepted=%0d pulses=%0d data=%02h,%02h", idx, n_pulse, cap[0], cap[1]);
        check("held-valid accepted", idx, 2);
        check("held-valid pulses", n_pulse, 2);
        check("held-valid byte0", int'(cap[0]), 'h30);
        check("held-valid byte1", int'(cap[1]), 'h31);

        // Reset in the second enable cycle of a user write.
        while (!o_cmd_rdy) @(negedge i_clk);
        i_cmd_vld = 1'b1; i_cmd_rs = 1'b1; i_cmd_data = 8'h55;
        @(negedge i_clk);
        i_cmd_vld = 1'b0;
        repeat (3) @(negedge i_clk);
        check("pre-reset en", int'(o_lcd_en), 1);
        check("pre-reset data", int'(o_lcd_data), 'h55);
        #1 i_reset = 1'b1;
        #1 check_all_zero("mid-pulse reset");
        $display("mid-pulse reset: en=%0d data=%02h", o_lcd_en, o_lcd_data);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        check_init_seq(1'b1, "after reset");

        check("lcd_on/rw errs", misc_err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
